demux_stream: RTL and testbench

// - Inverse of the team's 2:1 byte mux: routes one 8-bit valid/ready input stream to one of two output

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_fifo.sv | 63 ++++++
 rtl/demux_stream.sv | 93 +++++++++
 tb/tb_demux_stream.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
//--------------------------------------------------------------------
// Module : demux_pkg
// Shared constants for the 1:2 byte stream demultiplexer.
// Rev 1.0 - initial release
//--------------------------------------------------------------------
`default_nettype none

package demux_pkg;
   localparam int   DEF_WIDTH = 8;
   localparam logic SEL_A     = 1'b1;   // same encoding as the 2:1 byte mux
   localparam logic SEL_B     = 1'b0;
   localparam int   STAT_W    = 16;
endpackage

`default_nettype wire

// File: rtl/demux_fifo.sv
//--------------------------------------------------------------------
// Module : demux_fifo
// Synchronous FIFO with registered storage; head is the oldest entry.
// Rev 1.0 - initial release
//--------------------------------------------------------------------
`default_nettype none

module demux_fifo
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;
   assign head      = r_mem[r_rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_do_pop) r_rptr <= r_rptr + 1'b1;
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/demux_stream.sv
//--------------------------------------------------------------------
// Module : demux_stream
// Routes one valid/ready byte stream to output A (sel=1) or B (sel=0),
// each behind its own FIFO. Optional per-output transfer counters are
// enabled with the DEMUX_STATS_EN macro.
// Rev 1.0 - initial release
//--------------------------------------------------------------------
`default_nettype none

module demux_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WIDTH-1:0]  a_data,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [WIDTH-1:0]  b_data,
   output logic              b_valid,
   input  logic              b_ready
`ifdef DEMUX_STATS_EN
   ,
   output logic [STAT_W-1:0] cnt_a,
   output logic [STAT_W-1:0] cnt_b
`endif
);

   logic w_full_a, w_full_b;
   logic w_empty_a, w_empty_b;
   logic w_accept, w_push_a, w_push_b;

   // Readiness depends only on the selected FIFO, never on in_valid.
   assign in_ready = (in_sel == SEL_A) ? ~w_full_a : ~w_full_b;
   assign w_accept = in_valid & in_ready;
   assign w_push_a = w_accept & (in_sel == SEL_A);
   assign w_push_b = w_accept & (in_sel == SEL_B);

   assign a_valid  = ~w_empty_a;
   assign b_valid  = ~w_empty_b;

   demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push_a),
      .push_data (in_data),
      .pop       (a_ready),
      .head      (a_data),
      .full      (w_full_a),
      .empty     (w_empty_a)
   );

   demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push_b),
      .push_data (in_data),
      .pop       (b_ready),
      .head      (b_data),
      .full      (w_full_b),
      .empty     (w_empty_b)
   );

`ifdef DEMUX_STATS_EN
   logic [STAT_W-1:0] r_cnt_a;
   logic [STAT_W-1:0] r_cnt_b;

   // Saturating counters: stick at all-ones rather than wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt_a <= '0;
         r_cnt_b <= '0;
      end else begin
         if (w_push_a && (r_cnt_a != '1)) r_cnt_a <= r_cnt_a + 1'b1;
         if (w_push_b && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + 1'b1;
      end
   end

   assign cnt_a = r_cnt_a;
   assign cnt_b = r_cnt_b;
`else
   // Statistics disabled: datapath only.
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_stream.sv
//--------------------------------------------------------------------
// Module : tb_demux_stream
// Directed self-checking bench for demux_stream.
// Rev 1.0 - initial release
//--------------------------------------------------------------------
`default_nettype none

module tb_demux_stream;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;
`ifdef DEMUX_STATS_EN
   logic [15:0]      cnt_a;
   logic [15:0]      cnt_b;
`endif

   int n_checks;
   int n_errors;

   demux_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b_data   (b_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready)
`ifdef DEMUX_STATS_EN
      ,
      .cnt_a    (cnt_a),
      .cnt_b    (cnt_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      in_data  = '0;
      in_sel   = 1'b0;
      in_valid = 1'b0;
      a_ready  = 1'b1;
      b_ready  = 1'b1;
      repeat (3) tick();
      #2 rst = 1'b0;
      #1;

      // Reset state
      chk("rst_a_valid", 32'(a_valid), 32'd0);
      chk("rst_b_valid", 32'(b_valid), 32'd0);
      chk("rst_a_data",  32'(a_data),  32'h0);
      chk("rst_b_data",  32'(b_data),  32'h0);
      chk("rst_in_ready_b", 32'(in_ready), 32'd1);
      in_sel = 1'b1;
      #1 chk("rst_in_ready_a", 32'(in_ready), 32'd1);
`ifdef DEMUX_STATS_EN
      chk("rst_cnt_a", 32'(cnt_a), 32'd0);
      chk("rst_cnt_b", 32'(cnt_b), 32'd0);
`endif

      // Route: 0x11 to A, then 0x22 to B
      tick();
      in_valid = 1'b1; in_data = 8'h11; in_sel = 1'b1;
      tick();
      chk("route_a_valid", 32'(a_valid), 32'd1);
      chk("route_a_data",  32'(a_data),  32'h11);
      chk("route_b_idle",  32'(b_valid), 32'd0);
      in_data = 8'h22; in_sel = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("route_b_valid", 32'(b_valid), 32'd1);
      chk("route_b_data",  32'(b_data),  32'h22);
      chk("route_a_popped", 32'(a_valid), 32'd0);
      tick();
      chk("route_b_popped", 32'(b_valid), 32'd0);

      // Fill A while its sink stalls
      a_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hA0 + 8'(i);
         #1 chk("fill_ready", 32'(in_ready), 32'd1);
         tick();
      end
      in_data = 8'hA4;
      #1 chk("full_a_ready", 32'(in_ready), 32'd0);
      in_sel = 1'b0; in_data = 8'hB5;
      #1 chk("full_b_open", 32'(in_ready), 32'd1);
      tick();
      chk("full_b_valid", 32'(b_valid), 32'd1);
      chk("full_b_data",  32'(b_data),  32'hB5);

      // Drain A; a pop on a full FIFO still does not open in_ready
      in_valid = 1'b0; in_sel = 1'b1; a_ready = 1'b1;
      #1 chk("full_pop_ready", 32'(in_ready), 32'd0);
      chk("drain_0", 32'(a_data), 32'hA0);
      for (int i = 1; i < DEPTH; i++) begin
         tick();
         chk("drain_valid", 32'(a_valid), 32'd1);
         chk("drain_data",  32'(a_data),  32'hA0 + 32'(i));
      end
      tick();
      chk("drain_empty", 32'(a_valid), 32'd0);

      // Push while popping with two entries queued
      a_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h31;
      tick();
      in_data = 8'h32;
      tick();
      a_ready = 1'b1; in_data = 8'h55;
      tick();
      in_valid = 1'b0; a_ready = 1'b0;
      chk("pp_head", 32'(a_data), 32'h32);
      tick();
      chk("pp_hold", 32'(a_data), 32'h32);
      a_ready = 1'b1;
      tick();
      chk("pp_last_valid", 32'(a_valid), 32'd1);
      chk("pp_last", 32'(a_data), 32'h55);
      tick();
      chk("pp_empty", 32'(a_valid), 32'd0);

      // Reset mid-operation discards queued data
      a_ready = 1'b0; b_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h77;
      tick();
      in_sel = 1'b0; in_data = 8'h88;
      tick();
      in_valid = 1'b0;
      chk("pre_rst_a", 32'(a_valid), 32'd1);
      chk("pre_rst_b", 32'(b_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_a_valid", 32'(a_valid), 32'd0);
      chk("mid_rst_b_valid", 32'(b_valid), 32'd0);
      chk("mid_rst_a_data",  32'(a_data),  32'h0);
      @(negedge clk);
      rst = 1'b0;
      a_ready = 1'b1; b_ready = 1'b1;
      #1 chk("post_rst_ready", 32'(in_ready), 32'd1);
      tick();
      chk("post_rst_a_empty", 32'(a_valid), 32'd0);
      chk("post_rst_b_empty", 32'(b_valid), 32'd0);

`ifdef DEMUX_STATS_EN
      chk("stat_clear_a", 32'(cnt_a), 32'd0);
      in_valid = 1'b1;
      in_sel = 1'b1; in_data = 8'h01; tick();
      in_data = 8'h02; tick();
      in_sel = 1'b0; in_data = 8'h03; tick();
      in_sel = 1'b1; in_data = 8'h04; tick();
      in_valid = 1'b0;
      chk("stat_cnt_a", 32'(cnt_a), 32'd3);
      chk("stat_cnt_b", 32'(cnt_b), 32'd1);
      // Push A every cycle with its sink draining until the counter saturates
      in_valid = 1'b1; in_sel = 1'b1;
      for (int i = 0; i < 65535; i++) tick();
      in_valid = 1'b0;
      chk("stat_sat_a", 32'(cnt_a), 32'hFFFF);
      chk("stat_sat_b", 32'(cnt_b), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
